// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: op codes, flag bit positions and FSM states.
package alu_pkg;

    localparam logic [3:0] OP_COPY = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_OR   = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_NOT  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_SWAP = 4'h7;
    localparam logic [3:0] OP_HIGH = 4'h8;
    localparam logic [3:0] OP_LOW  = 4'h9;
    localparam logic [3:0] OP_ADD  = 4'hA;
    localparam logic [3:0] OP_SUB  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_DIV  = 4'hD;
    localparam logic [3:0] OP_REM  = 4'hE;
    localparam logic [3:0] OP_MULH = 4'hF;

    localparam int FLAG_ZERO   = 0;
    localparam int FLAG_NEG    = 1;
    localparam int FLAG_CARRY  = 2;
    localparam int FLAG_OVF    = 3;
    localparam int FLAG_DIVERR = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic is_iter_op(input logic [3:0] op);
        return op >= OP_MUL;
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned shift-add multiplier and restoring divider, one bit per cycle,
// sharing a single 2*WIDTH accumulator. The first step is folded into the start cycle.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   b_q;
    logic               mode_q;
    logic [CNT_W-1:0]   cnt;
    logic               running;

    // Multiply: acc = {partial, multiplier}, add to the top half and shift right.
    // Divide:   acc = {partial remainder, dividend/quotient}, shift left and trial-subtract.
    function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] acc_cur,
                                                input logic [WIDTH-1:0]   opnd,
                                                input logic               is_div);
        logic [WIDTH:0]          sum;
        logic [WIDTH:0]          rem_sh;
        logic signed [WIDTH+1:0] diff;
        sum    = {1'b0, acc_cur[2*WIDTH-1:WIDTH]} + (acc_cur[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        rem_sh = {acc_cur[2*WIDTH-1:WIDTH], acc_cur[WIDTH-1]};
        diff   = $signed({1'b0, rem_sh}) - $signed({2'b00, opnd});
        if (!is_div)
            return {sum, acc_cur[WIDTH-1:1]};
        else if (diff >= 0)
            return {diff[WIDTH-1:0], acc_cur[WIDTH-2:0], 1'b1};
        else
            return {rem_sh[WIDTH-1:0], acc_cur[WIDTH-2:0], 1'b0};
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            running <= 1'b0;
            cnt     <= '0;
        end else if (start) begin
            running <= 1'b1;
            cnt     <= CNT_W'(WIDTH - 1);
        end else if (running) begin
            if (cnt == '0)
                running <= 1'b0;
            else
                cnt <= cnt - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (start) begin
            acc    <= step({{WIDTH{1'b0}}, a}, b, mode);
            b_q    <= b;
            mode_q <= mode;
        end else if (running && (cnt != '0)) begin
            acc <= step(acc, b_q, mode_q);
        end
    end

    assign done      = running && (cnt == '0);
    assign product   = acc;
    assign quotient  = acc[WIDTH-1:0];
    assign remainder = acc[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes; single-cycle logic/arith ops and
// iterative multiply/divide behind a three-state FSM.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH         = 16,
    parameter int SIGN_FLAG_BIT = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op_code,
    input  logic [WIDTH-1:0] source,
    input  logic [WIDTH-1:0] destination,
    input  logic [15:0]      flags_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [15:0]      flags_out,
    output logic             write_flags
);

    localparam int HALF = WIDTH / 2;

    state_t state, state_nxt;

    logic               accept;
    logic               div_zero;
    logic               go_iter;
    logic [3:0]         op_q;
    logic [15:5]        flags_hi_q;
    logic               unused_flag_bits;

    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry;
    logic               sc_ovf;
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic signed [WIDTH-1:0] src_s, dst_s, sum_s, diff_s;
    logic               fill;
    logic               shamt_big;

    logic               iter_done;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   it_res;
    logic               it_carry;
    logic               it_ovf;

    function automatic logic [15:0] pack_flags(input logic [15:5]      hi,
                                               input logic [WIDTH-1:0] res,
                                               input logic             div_err,
                                               input logic             ovf,
                                               input logic             carry);
        logic [15:0] f;
        f              = '0;
        f[15:5]        = hi;
        f[FLAG_ZERO]   = (res == '0);
        f[FLAG_NEG]    = res[WIDTH-1];
        f[FLAG_CARRY]  = carry;
        f[FLAG_OVF]    = ovf;
        f[FLAG_DIVERR] = div_err;
        return f;
    endfunction

    assign unused_flag_bits = ^flags_in[4:0];

    assign accept   = in_valid && (state == IDLE);
    assign div_zero = is_div_op(op_code) && (destination == '0);
    assign go_iter  = accept && is_iter_op(op_code) && !div_zero;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (is_iter_op(op_code) && !div_zero) ? BUSY : DONE;
            end
            BUSY: begin
                if (iter_done)
                    state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle datapath, evaluated directly on the request operands.
    assign src_s     = $signed(source);
    assign dst_s     = $signed(destination);
    assign sum_ext   = {1'b0, source} + {1'b0, destination};
    assign diff_ext  = {1'b0, source} - {1'b0, destination};
    assign sum_s     = src_s + dst_s;
    assign diff_s    = src_s - dst_s;
    assign fill      = flags_in[SIGN_FLAG_BIT] & destination[WIDTH-1];
    assign shamt_big = source >= WIDTH'(WIDTH);

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (op_code)
            OP_COPY: sc_res = source;
            OP_AND:  sc_res = source & destination;
            OP_OR:   sc_res = source | destination;
            OP_XOR:  sc_res = source ^ destination;
            OP_NOT:  sc_res = ~source;
            OP_SHL:  sc_res = shamt_big ? '0 : (destination << source);
            OP_SHR: begin
                if (shamt_big)
                    sc_res = {WIDTH{fill}};
                else if (fill)
                    sc_res = dst_s >>> source;
                else
                    sc_res = destination >> source;
            end
            OP_SWAP: sc_res = {source[HALF-1:0], source[WIDTH-1:HALF]};
            OP_HIGH: sc_res = {source[WIDTH-1:HALF], {HALF{1'b0}}};
            OP_LOW:  sc_res = {{HALF{1'b0}}, source[HALF-1:0]};
            OP_ADD: begin
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
                sc_ovf   = ((src_s < 0) == (dst_s < 0)) && ((sum_s < 0) != (src_s < 0));
            end
            OP_SUB: begin
                sc_res   = diff_ext[WIDTH-1:0];
                sc_carry = diff_ext[WIDTH];
                sc_ovf   = ((src_s < 0) != (dst_s < 0)) && ((diff_s < 0) != (src_s < 0));
            end
            // Divide ops only take this path on a zero divisor.
            OP_DIV:  sc_res = '1;
            OP_REM:  sc_res = source;
            default: sc_res = '0;
        endcase
    end

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (go_iter),
        .mode      (is_div_op(op_code)),
        .a         (source),
        .b         (destination),
        .done      (iter_done),
        .product   (product),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always_comb begin
        it_res   = remainder;
        it_carry = 1'b0;
        case (op_q)
            OP_MUL: begin
                it_res   = product[WIDTH-1:0];
                it_carry = |product[2*WIDTH-1:WIDTH];
            end
            OP_MULH: it_res = product[2*WIDTH-1:WIDTH];
            OP_DIV:  it_res = quotient;
            default: it_res = remainder;
        endcase
    end

    assign it_ovf = it_carry;

    always_ff @(posedge clock) begin
        if (accept) begin
            op_q       <= op_code;
            flags_hi_q <= flags_in[15:5];
        end
    end

    // Output registers: loaded at accept for single-cycle ops, at iteration end otherwise.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result      <= '0;
            flags_out   <= '0;
            write_flags <= 1'b0;
        end else if (accept && !go_iter) begin
            result      <= sc_res;
            flags_out   <= pack_flags(flags_in[15:5], sc_res, div_zero, sc_ovf, sc_carry);
            write_flags <= (op_code != OP_COPY);
        end else if ((state == BUSY) && iter_done) begin
            result      <= it_res;
            flags_out   <= pack_flags(flags_hi_q, it_res, 1'b0, it_ovf, it_carry);
            write_flags <= (op_q != OP_COPY);
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed scoreboard bench for seq_alu at WIDTH=16: driver pushes expectations,
// monitor pops and compares on each output handshake, including latency.
module tb_seq_alu;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op_code;
    logic [15:0] source;
    logic [15:0] destination;
    logic [15:0] flags_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic [15:0] flags_out;
    logic        write_flags;

    typedef struct {
        string       name;
        logic [15:0] res;
        logic [15:0] flg;
        logic        wf;
        int          acc_cyc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    seq_alu #(.WIDTH(16), .SIGN_FLAG_BIT(8)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_code     (op_code),
        .source      (source),
        .destination (destination),
        .flags_in    (flags_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .flags_out   (flags_out),
        .write_flags (write_flags)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic issue(input string nm, input logic [3:0] op, input logic [15:0] s,
                         input logic [15:0] d, input logic [15:0] fl,
                         input logic [15:0] er, input logic [15:0] ef, input int lat);
        exp_t e;
        bit   got;
        got = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        in_valid    = 1'b1;
        op_code     = op;
        source      = s;
        destination = d;
        flags_in    = fl;
        e.name = nm; e.res = er; e.flg = ef; e.wf = (op != 4'h0);
        e.acc_cyc = cyc; e.lat = lat;
        sb.push_back(e);
        @(posedge clock);
        #1;
        // Scramble the operands after accept; they must already be captured.
        in_valid    = 1'b0;
        op_code     = ~op;
        source      = ~s;
        destination = ~d;
        flags_in    = ~fl;
    endtask

    // Monitor: compares on every output transfer.
    initial begin : monitor
        exp_t e;
        logic prev_ov;
        int   rise;
        prev_ov = 1'b0;
        rise    = 0;
        forever begin
            @(negedge clock);
            if (reset_n && out_valid) begin
                if (!prev_ov) rise = cyc;
                if (out_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_output", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk({e.name, "_res"}, {16'd0, result}, {16'd0, e.res});
                        chk({e.name, "_flags"}, {16'd0, flags_out}, {16'd0, e.flg});
                        chk({e.name, "_wf"}, {31'd0, write_flags}, {31'd0, e.wf});
                        chk({e.name, "_lat"}, rise - e.acc_cyc, e.lat);
                    end
                end
            end
            prev_ov = reset_n && out_valid;
        end
    end

    initial begin : driver
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        op_code     = 4'h0;
        source      = '0;
        destination = '0;
        flags_in    = '0;
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_flags", {16'd0, flags_out}, 32'd0);
        chk("rst_wf", {31'd0, write_flags}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        issue("add_ovf",   4'hA, 16'h7FFF, 16'h0001, 16'h0000, 16'h8000, 16'h000A, 1);
        issue("sub_borrow",4'hB, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 16'h0006, 1);
        issue("add_carry", 4'hA, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0005, 1);
        issue("sub_ovf",   4'hB, 16'h8000, 16'h0001, 16'h0000, 16'h7FFF, 16'h0008, 1);
        issue("mul_lo",    4'hC, 16'h1234, 16'h0100, 16'h0000, 16'h3400, 16'h000C, 17);
        issue("mul_hi",    4'hF, 16'h1234, 16'h0100, 16'h0000, 16'h0012, 16'h0000, 17);
        issue("mul_lo_max",4'hC, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0001, 16'h000C, 17);
        issue("mul_hi_max",4'hF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h0002, 17);
        issue("div_q",     4'hD, 16'd100,  16'd7,    16'h0000, 16'h000E, 16'h0000, 17);
        issue("div_r",     4'hE, 16'd100,  16'd7,    16'h0000, 16'h0002, 16'h0000, 17);
        issue("div_big",   4'hD, 16'hFFFF, 16'h0001, 16'h0000, 16'hFFFF, 16'h0002, 17);
        issue("rem_big",   4'hE, 16'hFFFF, 16'h0010, 16'h0000, 16'h000F, 16'h0000, 17);
        issue("div_small", 4'hD, 16'd3,    16'd7,    16'h0000, 16'h0000, 16'h0001, 17);
        issue("div_zero_q",4'hD, 16'd5,    16'd0,    16'h0000, 16'hFFFF, 16'h0012, 1);
        issue("div_zero_r",4'hE, 16'd5,    16'd0,    16'h0000, 16'h0005, 16'h0010, 1);
        issue("shr_sign",  4'h6, 16'd4,    16'h8000, 16'h0100, 16'hF800, 16'h0102, 1);
        issue("shr_sign20",4'h6, 16'd20,   16'h8000, 16'h0100, 16'hFFFF, 16'h0102, 1);
        issue("shr_logic", 4'h6, 16'd4,    16'h8000, 16'h0000, 16'h0800, 16'h0000, 1);
        issue("shl_16",    4'h5, 16'd16,   16'h00FF, 16'h0000, 16'h0000, 16'h0001, 1);
        issue("shl_4",     4'h5, 16'd4,    16'h00FF, 16'h0000, 16'h0FF0, 16'h0000, 1);
        issue("and",       4'h1, 16'hF0F0, 16'h3C3C, 16'h0000, 16'h3030, 16'h0000, 1);
        issue("or",        4'h2, 16'h0F00, 16'h00F0, 16'h0000, 16'h0FF0, 16'h0000, 1);
        issue("xor",       4'h3, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0001, 1);
        issue("not",       4'h4, 16'h00FF, 16'h0000, 16'h0000, 16'hFF00, 16'h0002, 1);
        issue("swap",      4'h7, 16'h12AB, 16'h0000, 16'h0000, 16'hAB12, 16'h0002, 1);
        issue("high",      4'h8, 16'h12AB, 16'h0000, 16'h0000, 16'h1200, 16'h0000, 1);
        issue("low",       4'h9, 16'h12AB, 16'h0000, 16'h0000, 16'h00AB, 16'h0000, 1);
        issue("copy_zero", 4'h0, 16'h0000, 16'h1234, 16'hFFFF, 16'h0000, 16'hFFE1, 1);

        // Backpressure: hold the result, ignore a new request meanwhile.
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        issue("and_bp",    4'h1, 16'hFF00, 16'h0F0F, 16'h0000, 16'h0F00, 16'h0000, 1);
        in_valid    = 1'b1;
        op_code     = 4'hA;
        source      = 16'h0001;
        destination = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            chk("bp_result", {16'd0, result}, 32'h0F00);
            chk("bp_flags", {16'd0, flags_out}, 32'h0000);
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);

        // Reset in the middle of a divide: its result must never appear.
        issue("div_rst",   4'hD, 16'd1000, 16'd3,    16'h0000, 16'h014D, 16'h0000, 17);
        repeat (7) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("midrst_result", {16'd0, result}, 32'd0);
        chk("midrst_flags", {16'd0, flags_out}, 32'd0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        issue("copy_after",4'h0, 16'h00AB, 16'h0000, 16'hA5E0, 16'h00AB, 16'hA5E0, 1);
        issue("div_after", 4'hD, 16'd1000, 16'd3,    16'h0000, 16'h014D, 16'h0000, 17);

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        chk("drain", sb.size(), 32'd0);
        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
